// File: rtl/fetch_cycle.sv
// Instruction fetch stage: PC, single outstanding imem read, small instruction buffer, redirect flush.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_cycle #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            f_to_d_enable_ff,
    output logic            instr_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] PC_out
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetch_count,
    output logic [31:0]     stat_flush_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   req_pc_r;
    logic [XLEN-1:0]   instr_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0]   pc_mem_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              imem_req_r;
    logic [XLEN-1:0]   imem_addr_r;
    logic              instr_valid_r;
    logic [XLEN-1:0]   instruction_r;
    logic [XLEN-1:0]   pc_out_r;

    logic              handshake_s;
    logic              push_s;
    logic              pop_s;
    state_t            state_n_s;
    logic [XLEN-1:0]   pc_n_s;
    logic [CNT_W-1:0]  count_n_s;
    logic [PTR_W-1:0]  rd_ptr_n_s;
    logic [PTR_W-1:0]  wr_ptr_n_s;
    logic              imem_req_n_s;
    logic [XLEN-1:0]   head_instr_s;
    logic [XLEN-1:0]   head_pc_s;

    // Next-state computation; redirect overrides every other update.
    always_comb begin
        handshake_s  = (state_r == FETCH) && imem_req_r && imem_ready;
        push_s       = (state_r == WAIT) && imem_rvalid && !redirect_valid;
        pop_s        = instr_valid_r && f_to_d_enable_ff && !redirect_valid;
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        count_n_s    = count_r;
        rd_ptr_n_s   = rd_ptr_r;
        wr_ptr_n_s   = wr_ptr_r;
        head_instr_s = NOP_INSTR;
        head_pc_s    = pc_r;

        case (state_r)
            FETCH: begin
                if (handshake_s) begin
                    state_n_s = redirect_valid ? DRAIN : WAIT;
                end else begin
                    state_n_s = FETCH;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_n_s = FETCH;
                end else if (redirect_valid) begin
                    state_n_s = DRAIN;
                end else begin
                    state_n_s = WAIT;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_n_s = FETCH;
                end else begin
                    state_n_s = DRAIN;
                end
            end
            default: begin
                state_n_s = FETCH;
            end
        endcase

        if (redirect_valid) begin
            pc_n_s = redirect_pc & ~(XLEN'(3));
        end else if (handshake_s) begin
            pc_n_s = pc_r + XLEN'(4);
        end else begin
            pc_n_s = pc_r;
        end

        if (redirect_valid) begin
            count_n_s  = {CNT_W{1'b0}};
            rd_ptr_n_s = {PTR_W{1'b0}};
            wr_ptr_n_s = {PTR_W{1'b0}};
        end else begin
            count_n_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_n_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_n_s = wr_ptr_r + PTR_W'(push_s);
        end

        // The word being pushed is not yet in the buffer, so bypass it when it becomes the head.
        if (count_n_s == {CNT_W{1'b0}}) begin
            head_instr_s = NOP_INSTR;
            head_pc_s    = pc_n_s;
        end else if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_instr_s = imem_rdata;
            head_pc_s    = req_pc_r;
        end else begin
            head_instr_s = instr_mem_r[rd_ptr_n_s];
            head_pc_s    = pc_mem_r[rd_ptr_n_s];
        end

        imem_req_n_s = (state_n_s == FETCH) && (count_n_s < DEPTH_C);
    end

    // State, buffer and registered output update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            req_pc_r      <= RESET_PC;
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_PC;
            instr_valid_r <= 1'b0;
            instruction_r <= NOP_INSTR;
            pc_out_r      <= RESET_PC;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_r[i] <= {XLEN{1'b0}};
                pc_mem_r[i]    <= {XLEN{1'b0}};
            end
        end else begin
            state_r       <= state_n_s;
            pc_r          <= pc_n_s;
            rd_ptr_r      <= rd_ptr_n_s;
            wr_ptr_r      <= wr_ptr_n_s;
            count_r       <= count_n_s;
            imem_req_r    <= imem_req_n_s;
            imem_addr_r   <= pc_n_s;
            instr_valid_r <= (count_n_s != {CNT_W{1'b0}});
            instruction_r <= head_instr_s;
            pc_out_r      <= head_pc_s;
            if (handshake_s) begin
                req_pc_r <= pc_r;
            end
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]    <= req_pc_r;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Popped-instruction and redirect counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetch_count <= 32'd0;
            stat_flush_count <= 32'd0;
        end else begin
            if (pop_s) begin
                stat_fetch_count <= stat_fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                stat_flush_count <= stat_flush_count + 32'd1;
            end
        end
    end
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instruction = instruction_r;
    assign PC_out      = pc_out_r;

endmodule

// File: tb/tb_fetch_cycle.sv
// Self-checking bench for fetch_cycle: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f_to_d_enable_ff;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] PC_out;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetch_count;
    logic [31:0] stat_flush_count;
`endif

    always #5 clk = ~clk;

    fetch_cycle dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .f_to_d_enable_ff(f_to_d_enable_ff),
        .instr_valid(instr_valid), .instruction(instruction), .PC_out(PC_out)
`ifdef FETCH_STATS_EN
        , .stat_fetch_count(stat_fetch_count), .stat_flush_count(stat_flush_count)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model: expected decode-visible queue plus one outstanding-request flag.
    entry_t      q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_addr;
    bit          m_out, m_disc, m_live;
    int          m_pops, m_flushes;

    // Memory model: one pending response with programmable latency.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_min = 1, lat_max = 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic bit m_req();
        return m_live && !m_out && (q.size() < 2);
    endfunction

    task automatic do_reset();
        rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; f_to_d_enable_ff = 1'b0;
        @(posedge clk);
        q.delete(); m_pc = 32'h0; m_out = 0; m_disc = 0; m_live = 0;
        m_pops = 0; m_flushes = 0; mem_pend = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
    task automatic drive_cycle(input bit rdy, input bit en, input bit redir, input logic [31:0] rpc);
        bit rv, hs, mhs, pop;
        entry_t dummy;
        rv = 0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin rv = 1; mem_pend = 0; end
        end
        imem_ready = rdy; f_to_d_enable_ff = en; redirect_valid = redir; redirect_pc = rpc;
        imem_rvalid = rv;
        imem_rdata  = rv ? memword(mem_addr) : $urandom();
        hs  = imem_req && rdy;
        mhs = m_req() && rdy;
        if (hs) begin
            mem_pend = 1; mem_cnt = $urandom_range(lat_max, lat_min); mem_addr = imem_addr;
        end
        @(posedge clk);
        pop = (q.size() != 0) && en && !redir;
        if (pop) begin dummy = q.pop_front(); m_pops++; end
        if (m_out && rv) begin
            m_out = 0;
            if (!m_disc && !redir) q.push_back('{m_req_addr, memword(m_req_addr)});
        end
        if (mhs) begin m_out = 1; m_disc = 0; m_req_addr = m_pc; m_pc = m_pc + 32'd4; end
        if (redir) begin
            q.delete(); m_pc = rpc & 32'hFFFF_FFFC; m_flushes++;
            if (m_out) m_disc = 1;
        end
        m_live = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({imem_req, instr_valid, instruction, PC_out, imem_addr} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b vld=%0b instr=%h pc=%h addr=%h, want 0 0 %h 0 0",
                     imem_req, instr_valid, instruction, PC_out, imem_addr, NOP);
        end
    endtask

    task automatic test_first_fetch();
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL first_req: got req=%0b addr=%h, want 1 0", imem_req, imem_addr);
        end
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait_state: got req=%0b vld=%0b, want 0 0", imem_req, instr_valid);
        end
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if ({instr_valid, PC_out, instruction, imem_req, imem_addr} !== {1'b1, 32'h0, 32'h0050_0093, 1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL first_latency: got vld=%0b pc=%h instr=%h req=%0b addr=%h, want 1 0 00500093 1 4",
                     instr_valid, PC_out, instruction, imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 0, 0, 32'h0);
            n_checks++;
            if (instr_valid !== 1'b1 || PC_out !== 32'h0 || instruction !== 32'h0050_0093) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got vld=%0b pc=%h instr=%h", i, instr_valid, PC_out, instruction);
            end
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL full_no_req: got req=%0b want 0", imem_req);
        end
        drive_cycle(0, 1, 0, 32'h0);
        n_checks++;
        if (instr_valid !== 1'b1 || PC_out !== 32'h4 || instruction !== memword(32'h4)) begin
            n_fail++; $display("FAIL drain_second: got vld=%0b pc=%h instr=%h want 1 4 %h",
                               instr_valid, PC_out, instruction, memword(32'h4));
        end
        drive_cycle(0, 1, 0, 32'h0);
        n_checks++;
        if (instr_valid !== 1'b0 || instruction !== NOP) begin
            n_fail++; $display("FAIL drain_empty: got vld=%0b instr=%h want 0 %h", instr_valid, instruction, NOP);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        lat_min = 4; lat_max = 4;
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(0, 0, 1, 32'h100);
        for (int i = 0; i < 10; i++) begin
            if (imem_req) break;
            n_checks++;
            if (instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL drain_leak: got vld=%0b pc=%h want 0", instr_valid, PC_out);
            end
            drive_cycle(1, 1, 0, 32'h0);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL redirect_restart: got req=%0b addr=%h want 1 100", imem_req, imem_addr);
        end
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if (instr_valid !== 1'b1 || PC_out !== 32'h100 || instruction !== memword(32'h100)) begin
            n_fail++; $display("FAIL redirect_target: got vld=%0b pc=%h instr=%h want 1 100 %h",
                               instr_valid, PC_out, instruction, memword(32'h100));
        end
    endtask

    task automatic test_align_hold();
        drive_cycle(0, 0, 1, 32'h103);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
                n_fail++; $display("FAIL align_hold: cycle %0d got req=%0b addr=%h vld=%0b want 1 100 0",
                                   i, imem_req, imem_addr, instr_valid);
            end
            if (i < 5) drive_cycle(0, 0, 0, 32'h0);
        end
    endtask

    task automatic test_wrap_reset();
        drive_cycle(0, 0, 1, 32'hFFFF_FFFC);
        n_checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_start: got addr=%h want fffffffc", imem_addr);
        end
        lat_min = 1; lat_max = 1;
        drive_cycle(1, 0, 0, 32'h0);
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if ({imem_req, imem_addr, instr_valid, PC_out} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_next: got req=%0b addr=%h vld=%0b pc=%h want 1 0 1 fffffffc",
                               imem_req, imem_addr, instr_valid, PC_out);
        end
        lat_min = 5; lat_max = 5;
        drive_cycle(1, 0, 0, 32'h0);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL wrap_wait: got req=%0b want 0", imem_req);
        end
        do_reset();
        n_checks++;
        if ({imem_req, instr_valid, instruction, PC_out, imem_addr} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL midwait_reset: got req=%0b vld=%0b instr=%h pc=%h addr=%h",
                               imem_req, instr_valid, instruction, PC_out, imem_addr);
        end
    endtask

    task automatic test_random();
        bit rdy, en, redir;
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int c = 0; c < 800; c++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            en    = (c % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            redir = ($urandom_range(0, 15) == 0);
            drive_cycle(rdy, en, redir, $urandom());
            n_checks++;
            if (imem_req !== m_req() || (m_req() && imem_addr !== m_pc)) begin
                n_fail++; $display("FAIL rand_req: cycle %0d got req=%0b addr=%h want %0b %h",
                                   c, imem_req, imem_addr, m_req(), m_pc);
            end
            n_checks++;
            if (q.size() != 0) begin
                if ({instr_valid, PC_out, instruction} !== {1'b1, q[0].pc, q[0].instr}) begin
                    n_fail++; $display("FAIL rand_head: cycle %0d got vld=%0b pc=%h instr=%h want 1 %h %h",
                                       c, instr_valid, PC_out, instruction, q[0].pc, q[0].instr);
                end
            end else if ({instr_valid, PC_out, instruction} !== {1'b0, m_pc, NOP}) begin
                n_fail++; $display("FAIL rand_empty: cycle %0d got vld=%0b pc=%h instr=%h want 0 %h %h",
                                   c, instr_valid, PC_out, instruction, m_pc, NOP);
            end
`ifdef FETCH_STATS_EN
            n_checks++;
            if (stat_fetch_count !== 32'(m_pops) || stat_flush_count !== 32'(m_flushes)) begin
                n_fail++; $display("FAIL rand_stats: got %0d %0d want %0d %0d",
                                   stat_fetch_count, stat_flush_count, m_pops, m_flushes);
            end
`endif
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        do_reset();
        n_checks++;
        if (stat_fetch_count !== 32'd0 || stat_flush_count !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset: got %0d %0d want 0 0", stat_fetch_count, stat_flush_count);
        end
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 60 && m_pops < 3; i++) drive_cycle(1, 1, 0, 32'h0);
        drive_cycle(0, 0, 1, 32'h200);
        n_checks++;
        if (stat_fetch_count !== 32'd3 || stat_flush_count !== 32'd1) begin
            n_fail++; $display("FAIL stats_count: got %0d %0d want 3 1", stat_fetch_count, stat_flush_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_align_hold();
        test_wrap_reset();
        test_random();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
